axis_result_streamer: RTL and testbench

//  Output-side AXI-Stream master for the matrix-multiply core. On start (driven from top done), reads
//  NUM_O_ELEMENTS words of matrix C from the core output BRAM port B. Streams them on m_axis_* with full
//  m_axis_tready backpressure and tlast on the final word. Replaces the unthrottled valid/last path into the
//  S2MM FIFO; fixed BRAM read latency is absorbed by a credit-limited prefetch FIFO.

---
 rtl/axis_result_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_axis_result_streamer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_result_streamer.sv
// axis_result_streamer: reads NUM_O_ELEMENTS result words from the core output BRAM (port B) and streams them on AXI-Stream.
// Latency: first tvalid RD_LATENCY+1 clock edges after the edge that accepts start; then 1 beat/cycle while tready=1.
// Backpressure: full m_axis_tready; BRAM reads are credit-limited so that in-flight reads plus queued words never exceed PF_DEPTH.
// Ports: aclk/aresetn clock and async active-low reset; start/busy/done frame control;
//        bram_enb/bram_addrb/bram_doutb BRAM port-B read; m_axis_tdata/tvalid/tready/tlast stream master.
// Optional: STREAMER_STALL_CNT_EN adds stall_cnt[31:0], the count of tvalid&&!tready cycles in the current/last frame.

// Small show-ahead FIFO used for the prefetch queue.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller never pushes when full.
module axis_result_streamer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;

    assign head_vld = (count != '0);
    // Data bus reads as zero when empty so the stream output is quiet between frames.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
    assign pop      = pop_rdy && head_vld;

    always_ff @(posedge aclk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
            case ({push_vld, pop})
                2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
                2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module axis_result_streamer #(
    parameter int WIDTH          = 16,
    parameter int CHUNK_SIZE     = 4,
    parameter int NUM_CORES      = 2,
    parameter int NUM_O_ELEMENTS = 6,
    parameter int RD_LATENCY     = 1,
    parameter int PF_DEPTH       = 4,
    // Derived from NUM_O_ELEMENTS; not meant to be overridden.
    parameter int ADDR_WIDTH     = (NUM_O_ELEMENTS > 1) ? $clog2(NUM_O_ELEMENTS) : 1
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  bram_enb,
    output logic [ADDR_WIDTH-1:0]                 bram_addrb,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] bram_doutb,
    input  logic                                  m_axis_tready,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] m_axis_tdata,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast
`ifdef STREAMER_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cnt
`endif
);
    localparam int DW    = WIDTH * CHUNK_SIZE * NUM_CORES;
    // Frame counters must be able to hold NUM_O_ELEMENTS itself (the "all issued" value).
    localparam int CNT_W = $clog2(NUM_O_ELEMENTS + 1);
    localparam int FC_W  = $clog2(PF_DEPTH) + 1;

    localparam logic [CNT_W-1:0] N_TOT  = CNT_W'(NUM_O_ELEMENTS);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(NUM_O_ELEMENTS - 1);
    localparam logic [FC_W:0]    PF_LIM = (FC_W+1)'(PF_DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       rd_cnt;
    logic [CNT_W-1:0]       beat_cnt;
    logic [RD_LATENCY-1:0]  vld_sr;
    logic [FC_W-1:0]        inflight;
    logic [FC_W-1:0]        fifo_cnt;
    logic                   start_acc;
    logic                   issue;
    logic                   capture;
    logic                   beat;
    logic                   last_beat;

    assign start_acc = (state == IDLE) && start;

    // Credit check counts reads still in the BRAM pipeline, including one whose
    // data lands this cycle, so a slot is reserved for every outstanding read.
    assign issue = (state == STREAM) && (rd_cnt < N_TOT) &&
                   (({1'b0, inflight} + {1'b0, fifo_cnt}) < PF_LIM);

    assign capture    = vld_sr[RD_LATENCY-1];
    assign beat       = m_axis_tvalid && m_axis_tready;
    assign last_beat  = beat && (beat_cnt == N_LAST);

    assign bram_enb     = issue;
    assign bram_addrb   = issue ? rd_cnt[ADDR_WIDTH-1:0] : '0;
    assign m_axis_tlast = m_axis_tvalid && (beat_cnt == N_LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (last_beat) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read tags travel alongside the BRAM pipeline; reset drops any in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_sr   <= '0;
            inflight <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
        end else begin
            vld_sr[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            case ({issue, capture})
                2'b10:   inflight <= inflight + FC_W'(1);
                2'b01:   inflight <= inflight - FC_W'(1);
                default: inflight <= inflight;
            endcase
            if (start_acc) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue) rd_cnt   <= rd_cnt + CNT_W'(1);
                if (beat)  beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    axis_result_streamer_fifo #(
        .W     (DW),
        .DEPTH (PF_DEPTH)
    ) u_pf_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push_vld (capture),
        .push_dat (bram_doutb),
        .pop_rdy  (m_axis_tready),
        .head_vld (m_axis_tvalid),
        .head_dat (m_axis_tdata),
        .count    (fifo_cnt)
    );

`ifdef STREAMER_STALL_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_result_streamer.sv
// Bench for axis_result_streamer: frames of result words checked against a scoreboard.
// Two instances: default parameters (6 words, latency 1) and a single-word, latency-3 build.
// Outputs are sampled on the falling edge; stimulus is driven 1-2 time units after the rising edge.
module tb_axis_result_streamer;
    localparam int DW = 128;
    localparam int CW = DW + 1;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn;
    int   cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        logic [15:0] v;
        v = 16'(i + 1);
        return {8{v}};
    endfunction

    // ---------------- instance 0: default build ----------------
    logic          start0, busy0, done0, enb0, tready0, tvalid0, tlast0;
    logic [2:0]    addr0;
    logic [DW-1:0] dout0, tdata0, pipe0;
`ifdef STREAMER_STALL_CNT_EN
    logic [31:0]   stall_cnt0;
`endif

    axis_result_streamer u_dut0 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start0),
        .busy          (busy0),
        .done          (done0),
        .bram_enb      (enb0),
        .bram_addrb    (addr0),
        .bram_doutb    (dout0),
        .m_axis_tready (tready0),
        .m_axis_tdata  (tdata0),
        .m_axis_tvalid (tvalid0),
        .m_axis_tlast  (tlast0)
`ifdef STREAMER_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt0)
`endif
    );

    always @(posedge aclk) if (enb0) pipe0 <= word_of(int'(addr0));
    assign dout0 = pipe0;

    // ---------------- instance 1: one word, read latency 3 ----------------
    logic          start1, busy1, done1, enb1, tready1, tvalid1, tlast1;
    logic [0:0]    addr1;
    logic [DW-1:0] dout1, tdata1;
    logic [DW-1:0] pipe1 [3];
`ifdef STREAMER_STALL_CNT_EN
    logic [31:0]   stall_cnt1;
`endif

    axis_result_streamer #(
        .NUM_O_ELEMENTS (1),
        .RD_LATENCY     (3)
    ) u_dut1 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start1),
        .busy          (busy1),
        .done          (done1),
        .bram_enb      (enb1),
        .bram_addrb    (addr1),
        .bram_doutb    (dout1),
        .m_axis_tready (tready1),
        .m_axis_tdata  (tdata1),
        .m_axis_tvalid (tvalid1),
        .m_axis_tlast  (tlast1)
`ifdef STREAMER_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt1)
`endif
    );

    always @(posedge aclk) begin
        pipe1[0] <= enb1 ? word_of(int'(addr1)) : '0;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign dout1 = pipe1[2];

    // ---------------- tready pattern driver for instance 0 ----------------
    int mode    = 0;   // 0: always ready, 1: 1,0,0 repeating, 2: never ready
    int tog_idx = 0;
    initial begin
        tready0 = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (mode)
                1: begin
                    tready0 = (tog_idx % 3 == 0);
                    tog_idx++;
                end
                2:       tready0 = 1'b0;
                default: tready0 = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboards and monitors ----------------
    logic [CW-1:0] q0 [$];
    logic [CW-1:0] q1 [$];

    int            exp_addr, enb_cnt, done_cnt, beats, stall_tb;
    int            first_vld_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
    bit            seen_vld, stalled_prev;
    logic [CW-1:0] prev_beat;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (enb0) begin
                chk("bram_addr", CW'(addr0), CW'(exp_addr));
                exp_addr++;
                enb_cnt++;
            end
            if (done0) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tvalid0 && !seen_vld) begin
                seen_vld      = 1'b1;
                first_vld_cyc = cyc;
            end
            if (stalled_prev) begin
                chk("hold_tvalid", CW'(tvalid0), CW'(1));
                chk("hold_beat", {tlast0, tdata0}, prev_beat);
            end
            if (tvalid0 && tready0) begin
                if (q0.size() == 0) chk("unexpected_beat", {tlast0, tdata0}, '0);
                else                chk("beat", {tlast0, tdata0}, q0.pop_front());
                beats++;
                if (beats == 1) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            if (tvalid0 && !tready0) stall_tb++;
            stalled_prev = tvalid0 && !tready0;
            prev_beat    = {tlast0, tdata0};
        end else begin
            stalled_prev = 1'b0;
        end
    end

    int  beats1 = 0, first_vld1 = 0, done1_cyc = 0;
    bit  seen_vld1 = 1'b0;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (tvalid1 && !seen_vld1) begin
                seen_vld1  = 1'b1;
                first_vld1 = cyc;
            end
            if (tvalid1 && tready1) begin
                if (q1.size() == 0) chk("unexpected_beat1", {tlast1, tdata1}, '0);
                else                chk("beat1", {tlast1, tdata1}, q1.pop_front());
                beats1++;
            end
            if (done1) done1_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    int start_cyc;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic frame_start0();
        exp_addr = 0; enb_cnt = 0; done_cnt = 0; beats = 0; stall_tb = 0;
        seen_vld = 1'b0; tog_idx = 0;
        start0 = 1'b1;
        for (int i = 0; i < 6; i++) q0.push_back({(i == 5), word_of(i)});
        tick();
        start0    = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", CW'(done_cnt), CW'(1));
    endtask

    task automatic frame_end_checks(input string tag);
        tick(3);
        chk({tag, "_beats"}, CW'(beats), CW'(6));
        chk({tag, "_queue_left"}, CW'(q0.size()), CW'(0));
        chk({tag, "_done_pulses"}, CW'(done_cnt), CW'(1));
        chk({tag, "_busy_after"}, CW'(busy0), CW'(0));
        chk({tag, "_reads"}, CW'(enb_cnt), CW'(6));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        aresetn = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        tready1 = 1'b1;
        #23;
        chk("rst_outputs0", {busy0, done0, enb0, tvalid0, tlast0, addr0}, '0);
        chk("rst_tdata0", CW'(tdata0), '0);
        chk("rst_outputs1", {busy1, done1, enb1, tvalid1, tlast1, addr1}, '0);
        tick();
        aresetn = 1'b1;
        tick(2);
        chk("idle_tvalid", CW'(tvalid0), CW'(0));

        // 1: always ready, consecutive beats
        mode = 0;
        frame_start0();
        chk("t1_busy", CW'(busy0), CW'(1));
        wait_done0(50);
        chk("t1_first_valid_lat", CW'(first_vld_cyc - start_cyc), CW'(2));
        chk("t1_burst_span", CW'(last_beat_cyc - first_beat_cyc), CW'(5));
        chk("t1_done_lat", CW'(done_cyc - last_beat_cyc), CW'(1));
        frame_end_checks("t1");

        // 2: tready 1,0,0 pattern
        mode = 1;
        frame_start0();
        wait_done0(100);
        frame_end_checks("t2");
`ifdef STREAMER_STALL_CNT_EN
        chk("t2_stall_cnt", CW'(stall_cnt0), CW'(stall_tb));
`endif
        mode = 0;

        // 3: no ready for 20 cycles, credit stops reads at PF_DEPTH
        mode = 2;
        frame_start0();
        tick(20);
        chk("t3_reads_stalled", CW'(enb_cnt), CW'(4));
        chk("t3_tvalid_held", CW'(tvalid0), CW'(1));
        chk("t3_tdata_held", CW'(tdata0), CW'(word_of(0)));
        mode = 0;
        wait_done0(50);
        frame_end_checks("t3");

        // 4: start re-pulsed mid-frame and in DONE
        frame_start0();
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int n = 0; n < 50 && !done0; n++) tick();
        chk("t4_done_seen", CW'(done0), CW'(1));
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(12);
        frame_end_checks("t4");

        // 5: reset after the third beat, then a clean frame
        frame_start0();
        for (int n = 0; n < 50 && beats < 3; n++) tick();
        chk("t5_three_beats", CW'(beats), CW'(3));
        aresetn = 1'b0;
        #1;
        chk("t5_rst_ctrl", {busy0, done0, enb0, addr0}, '0);
        chk("t5_rst_stream", {tvalid0, tlast0}, '0);
        chk("t5_rst_tdata", CW'(tdata0), '0);
        q0.delete();
        tick(2);
        aresetn = 1'b1;
        tick(2);
        chk("t5_idle_after_rst", CW'(tvalid0), CW'(0));
        frame_start0();
        wait_done0(50);
        frame_end_checks("t5");

        // 6: single word, read latency 3
        seen_vld1 = 1'b0;
        q1.push_back({1'b1, word_of(0)});
        start1 = 1'b1;
        tick();
        start1    = 1'b0;
        start_cyc = cyc;
        tick(10);
        chk("t6_first_valid_lat", CW'(first_vld1 - start_cyc), CW'(4));
        chk("t6_beats", CW'(beats1), CW'(1));
        chk("t6_done_lat", CW'(done1_cyc - first_vld1), CW'(1));
        chk("t6_queue_left", CW'(q1.size()), CW'(0));
        chk("t6_idle", {busy1, tvalid1}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
